// File: rtl/fizzle_writer.sv
// fizzle_writer: fills a framebuffer with one colour in pseudo-random pixel order.
// A Fibonacci LFSR walks every non-zero address once and address 0 is written first.
// Out-of-range LFSR values are skipped at one cycle each.
// Optional feature: define FIZZLE_PROGRESS_EN to add the 'progress' write counter output.
module fizzle_writer #(
    parameter int unsigned FB_WIDTH    = 160,
    parameter int unsigned FB_HEIGHT   = 120,
    parameter int unsigned ADDRW       = 15,
    parameter int unsigned DATAW       = 4,
    parameter int unsigned WAIT_FRAMES = 120,
    parameter int unsigned RATE        = 2000
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             start,
    input  logic             frame_sys,
    input  logic [DATAW-1:0] colr,
    output logic             busy,
    output logic             done,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr_write,
`ifdef FIZZLE_PROGRESS_EN
    output logic [ADDRW-1:0] progress,
`endif
    output logic [DATAW-1:0] fb_colr_write
);

    localparam int unsigned PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned RCW    = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int unsigned FCW    = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(RATE - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(WAIT_FRAMES - 1);
    localparam logic [ADDRW-1:0] SEED     = ADDRW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FADE,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [ADDRW-1:0] lfsr, lfsr_nxt;
    logic [FCW-1:0]   frame_cnt, frame_nxt;
    logic [RCW-1:0]   rate_cnt, rate_nxt;
    logic             first, first_nxt;
    logic [DATAW-1:0] colr_q, colr_nxt;
    logic             we_nxt;
    logic [ADDRW-1:0] addr_nxt;
    logic [DATAW-1:0] wcolr_nxt;
    logic [ADDRW-1:0] lfsr_step;
    logic             in_range;

    // Next LFSR value and whether the current one addresses a real pixel
    assign lfsr_step = {lfsr[ADDRW-2:0], lfsr[ADDRW-1] ^ lfsr[ADDRW-2]};
    assign in_range  = (32'(lfsr) < PIXELS);

    // State and output registers
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state         <= ST_IDLE;
            lfsr          <= SEED;
            frame_cnt     <= '0;
            rate_cnt      <= '0;
            first         <= 1'b0;
            colr_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fb_we         <= 1'b0;
            fb_addr_write <= '0;
            fb_colr_write <= '0;
        end else begin
            state         <= state_nxt;
            lfsr          <= lfsr_nxt;
            frame_cnt     <= frame_nxt;
            rate_cnt      <= rate_nxt;
            first         <= first_nxt;
            colr_q        <= colr_nxt;
            busy          <= (state_nxt != ST_IDLE);
            done          <= (state_nxt == ST_DONE);
            fb_we         <= we_nxt;
            fb_addr_write <= addr_nxt;
            fb_colr_write <= wcolr_nxt;
        end
    end

    // Next-state, counters, LFSR stepping and write-slot decisions
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        frame_nxt = frame_cnt;
        rate_nxt  = rate_cnt;
        first_nxt = first;
        colr_nxt  = colr_q;
        we_nxt    = 1'b0;
        addr_nxt  = fb_addr_write;
        wcolr_nxt = fb_colr_write;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    colr_nxt  = colr;
                    lfsr_nxt  = SEED;
                    frame_nxt = '0;
                    rate_nxt  = '0;
                    first_nxt = 1'b1;
                    state_nxt = (WAIT_FRAMES == 0) ? ST_FADE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (WAIT_FRAMES == 0) begin
                    state_nxt = ST_FADE;
                end else if (frame_sys) begin
                    if (frame_cnt == FRAME_LAST) begin
                        state_nxt = ST_FADE;
                    end else begin
                        frame_nxt = frame_cnt + FCW'(1);
                    end
                end
            end
            ST_FADE: begin
                if (rate_cnt != RATE_LAST) begin
                    rate_nxt = rate_cnt + RCW'(1);
                end else if (first) begin
                    // Address 0 is never produced by the LFSR, so it goes first
                    we_nxt    = 1'b1;
                    addr_nxt  = '0;
                    wcolr_nxt = colr_q;
                    first_nxt = 1'b0;
                    rate_nxt  = '0;
                end else begin
                    // Out-of-range values keep rate_cnt at its last value: retry next cycle
                    lfsr_nxt = lfsr_step;
                    if (in_range) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = lfsr;
                        wcolr_nxt = colr_q;
                        rate_nxt  = '0;
                    end
                    if (lfsr_step == SEED) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef FIZZLE_PROGRESS_EN
    // Number of pixels written since the last accepted start
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            progress <= '0;
        end else if (state == ST_IDLE && start) begin
            progress <= '0;
        end else if (we_nxt) begin
            progress <= progress + ADDRW'(1);
        end
    end
`endif

endmodule

// File: doc/fizzle_writer.md
FIZZLE_WRITER -- requirements
Module: fizzle_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter ADDRW, default 15, write address width and LFSR length; requires 2^ADDRW > FB_WIDTH*FB_HEIGHT.
REQ-004 SHALL have parameter DATAW, default 4, colour index width.
REQ-005 SHALL have parameter WAIT_FRAMES, default 120, frame pulses to wait before fading (0 allowed).
REQ-006 SHALL have parameter RATE, default 2000, system cycles per pixel write (>=1).
REQ-007 SHALL have ports: clk_sys  in  1  system clock; rst_sys_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: start  in  1  one-cycle start pulse; frame_sys  in  1  one-cycle frame-start pulse; colr  in  DATAW  fade colour index.
REQ-009 SHALL have ports: busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: fb_we  out  1  framebuffer write enable; fb_addr_write  out  ADDRW  write address; fb_colr_write  out  DATAW  write colour.

Function
REQ-011 SHALL implement states IDLE, WAIT, FADE, DONE.
REQ-012 SHALL, in IDLE on start, capture colr, load LFSR with seed 1, zero frame and rate counters, set first-pixel flag, and enter WAIT.
REQ-013 SHALL ignore start in any state other than IDLE.
REQ-014 SHALL, in WAIT, count frame_sys pulses and enter FADE on pulse number WAIT_FRAMES; WAIT_FRAMES=0 enters FADE the cycle after start.
REQ-015 SHALL use a Fibonacci LFSR: next = {sreg[ADDRW-2:0], sreg[ADDRW-1]^sreg[ADDRW-2]}, maximal length, never zero.
REQ-016 SHALL, in FADE, count rate counter 0..RATE-1; a write slot occurs when the counter equals RATE-1.
REQ-017 SHALL, at the first write slot, write address 0 (first-pixel flag), clear the flag, leave the LFSR unchanged, and reset the rate counter.
REQ-018 SHALL, at later slots with LFSR value < FB_WIDTH*FB_HEIGHT, write that address, step the LFSR, and reset the rate counter.
REQ-019 SHALL, at a slot with LFSR value >= FB_WIDTH*FB_HEIGHT, issue no write, step the LFSR, and hold the rate counter at RATE-1, so skipping costs one cycle per skipped value.
REQ-020 SHALL enter DONE when a step returns the LFSR to seed 1; the total is exactly FB_WIDTH*FB_HEIGHT writes, each address once.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and return to IDLE the next cycle.
REQ-022 SHALL register fb_we, fb_addr_write and fb_colr_write, asserting them the cycle after the slot decision; fb_we is high for one cycle per write.
REQ-023 SHALL hold fb_addr_write and fb_colr_write stable between writes.
REQ-024 SHALL, when RATE=1, write on every cycle with an in-range LFSR value.
REQ-025 SHALL assert busy in WAIT, FADE and DONE.

Reset
REQ-026 SHALL, while rst_sys_n is low, asynchronously force: state IDLE; busy, done and fb_we to 0; fb_addr_write and fb_colr_write to 0; LFSR to 1; all counters to 0.
REQ-027 SHALL abandon any fade in progress on reset, and the next start SHALL begin again from address 0.

Configuration
REQ-028 SHALL, with FIZZLE_PROGRESS_EN defined, add output progress (ADDRW), reset to 0, cleared on accepted start, incremented on each fb_we pulse, and held after done.
REQ-029 SHALL, without FIZZLE_PROGRESS_EN, omit the progress port and counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: assert rst_sys_n=0 mid-FADE -> fb_we=0, busy=0, done=0, fb_addr_write=0 immediately; start after release -> first write is address 0.
REQ-031 SHALL cover wait timing: WAIT_FRAMES=2, RATE=4, colr=7, start -> no fb_we before the 2nd frame_sys; first write is address 0 with colour 7; the next in-range write follows 4 cycles later.
REQ-032 SHALL cover a full run: WAIT_FRAMES=0, RATE=1 -> exactly 19200 fb_we pulses, addresses 0..19199 each once, none >=19200, one done pulse, then busy=0.
REQ-033 SHALL cover skipping: force an observed LFSR value >=19200 at a slot -> no fb_we that cycle, rate counter held, and a write at the next in-range value without waiting RATE cycles.
REQ-034 SHALL cover ignored start: pulse start during FADE -> no restart, address sequence and colour unchanged.
REQ-035 SHALL cover progress with FIZZLE_PROGRESS_EN: full run -> progress=19200 mod 2^15=19200 at done, then held; progress reads 0 after a new start.
